vga_sprite_timing: RTL and testbench
====================================

# vga_sprite_timing

Parametrised VGA timing generator with a multi-sprite rectangle compositor. It replaces the fixed 640x480 single-box generator in the display path. Timing, sprite count, sprite size and colour depth are configurable. Sprite position, colour and enable updates are written through a handshake port into shadow registers, and those registers take effect only at the frame boundary, so no frame is ever torn. It sits between the game/position logic and the VGA DAC pins.

## Interface
- H_SYNC, 96: horizontal sync pulse width, pixels
- H_BP, 48: horizontal back porch
- H_ACT, 640: horizontal active pixels
- H_FP, 16: horizontal front porch
- V_SYNC, 2: vertical sync pulse width, lines
- V_BP, 33: vertical back porch
- V_ACT, 480: vertical active lines
- V_FP, 10: vertical front porch
- CLK_DIV, 2: i_clk cycles per pixel (≥1)
- N_SPR, 4: number of sprites (1..8)
- SPR_W, 5 / SPR_H, 5: sprite width and height in pixels
- COLOR_W, 6: bits per colour channel
- XW, 10 / YW, 10: width of the position fields
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_valid  in  1  sprite update request
- o_wr_ready  out  1  update accepted when high together with i_wr_valid
- i_wr_sel  in  max(1,clog2(N_SPR))  sprite index to update
- i_wr_en  in  1  sprite visible
- i_x_pos  in  XW  sprite left edge, relative to the active area
- i_y_pos  in  YW  sprite top edge, relative to the active area
- i_color  in  3*COLOR_W  colour as {R,G,B}
- o_pix_ce  out  1  one-i_clk pulse per pixel
- o_hs, o_vs  out  1  syncs, active low
- o_de  out  1  data enable (active area)
- o_frame_start  out  1  one-pixel pulse at the first active pixel of each frame
- o_red, o_green, o_blue  out  COLOR_W  pixel colour
- o_hit  out  N_SPR  per-sprite coverage of the current output pixel

## Operation
- H_TOT = H_SYNC+H_BP+H_ACT+H_FP. V_TOT is defined the same way from the V_* parameters.
- Divider counts 0..CLK_DIV-1 on every i_clk. o_pix_ce is high when the divider equals CLK_DIV-1. With CLK_DIV=1, o_pix_ce is constantly high.
- Counters advance only on o_pix_ce:
  - h_cnt wraps at H_TOT-1 back to 0.
  - v_cnt increments when h_cnt wraps, and wraps at V_TOT-1. v_cnt only changes while h_cnt wraps.
- hs_raw is low while h_cnt < H_SYNC. vs_raw is low while v_cnt < V_SYNC.
- active is high when H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACT, and likewise for v_cnt. Both limits are half-open.
- Pixel coordinate: px = h_cnt-(H_SYNC+H_BP), py = v_cnt-(V_SYNC+V_BP).
- Sprite i hits when all of the following hold:
  - live_en[i] is set
  - x[i] ≤ px < x[i]+SPR_W
  - y[i] ≤ py < y[i]+SPR_H
  - active is high
- Hit comparisons use XW+1 / YW+1 bits, so an edge past the active area never wraps.
- Priority: the lowest-index hitting sprite supplies the colour. With no hit, or outside the active area, the colour is 0.
- Update handshake:
  - o_wr_ready is 1 except during the commit i_clk cycle.
  - An accepted write loads shadow[i_wr_sel]. An i_wr_sel ≥ N_SPR is accepted and discarded.
  - Repeated writes to the same sprite before a commit: the last one wins.
- Commit occurs on the o_pix_ce cycle where h_cnt=H_TOT-1 and v_cnt=V_TOT-1. All shadow registers copy to the live registers in that single cycle.

## Timing
- Outputs are registered on o_pix_ce. Colours, o_hit, o_de, o_hs, o_vs and o_frame_start are all delayed by exactly one pixel from the counters, so they stay mutually aligned.
- A write accepted in frame N becomes visible in frame N+1. A write during the commit cycle is impossible because o_wr_ready=0 then; the requester holds i_wr_valid.
- Reset values:
  - divider, h_cnt and v_cnt are 0.
  - o_pix_ce=0, o_hs=0, o_vs=0, o_de=0, o_frame_start=0.
  - All colour outputs and o_hit are 0; o_wr_ready=1.
  - Shadow and live registers: pos=0, color=all-ones, en=0.
- Reset mid-frame clears everything immediately (asynchronously). Timing restarts from h=0, v=0 once i_rst_n deasserts. Any pending shadow writes are lost.

## Configuration
- VGA_SPRITE_CLAMP_EN defined: at write acceptance, x is clamped to H_ACT-SPR_W and y to V_ACT-SPR_H, so a sprite is always fully on screen.
- Not defined: positions are stored unmodified. Sprites extending past the right or bottom edge are clipped by the active window. Positions wholly outside the active area draw nothing.

## Test plan
- Reset, default parameters, CLK_DIV=2:
  - o_pix_ce toggles every second i_clk.
  - o_hs is low for 96 of every 800 pixels; o_vs is low for 2 of every 525 lines.
  - o_de is high for 640×480 pixels per frame.
- Write sprite 0 at x=10, y=20, en=1, color all-ones during frame 0:
  - Frame 0 stays black.
  - In frame 1, o_hit[0]=1 and the output is white exactly on px 10..14, py 20..24.
- Sprites 0 and 1 overlap at (100,100), with colours red and blue: the overlapping pixels output red, and o_hit=4'b0011 there.
- Hold i_wr_valid across the commit cycle: o_wr_ready=0 for exactly one i_clk. The write is accepted on the next cycle and appears in the following frame.
- Write x=638, y=0 for a 5×5 sprite:
  - Without VGA_SPRITE_CLAMP_EN, only px 638..639 light.
  - With it, px 635..639 light.
- Assert i_rst_n=0 mid-line: all outputs return to their reset values within the same cycle. After release, the first o_frame_start comes 35×800+144 pixels later, plus the 1-pixel output latency.

Source files
------------

// File: rtl/vga_sprite_timing_if.sv
// Sprite update port: the game logic writes one sprite's position, colour
// and visibility per accepted transfer (valid/ready handshake).
interface vga_sprite_timing_if #(
    parameter int N_SPR   = 4,
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int COLOR_W = 6
);
    localparam int SW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

    logic                 i_wr_valid;
    logic                 o_wr_ready;
    logic [SW-1:0]        i_wr_sel;
    logic                 i_wr_en;
    logic [XW-1:0]        i_x_pos;
    logic [YW-1:0]        i_y_pos;
    logic [3*COLOR_W-1:0] i_color;

    modport master (
        output i_wr_valid, i_wr_sel, i_wr_en, i_x_pos, i_y_pos, i_color,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid, i_wr_sel, i_wr_en, i_x_pos, i_y_pos, i_color,
        output o_wr_ready
    );
endinterface

// File: rtl/vga_sprite_timing.sv
// Parametrised VGA timing generator with an N-sprite rectangle compositor.
// Sprite writes land in shadow registers and are copied to the live set in
// the last pixel of each frame, so a frame is never drawn with mixed state.
// Optional feature: define VGA_SPRITE_CLAMP_EN to clamp positions at write
// time so every sprite stays fully inside the active area.
module vga_sprite_timing #(
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int CLK_DIV = 2,
    parameter int N_SPR   = 4,
    parameter int SPR_W   = 5,
    parameter int SPR_H   = 5,
    parameter int COLOR_W = 6,
    parameter int XW      = 10,
    parameter int YW      = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    vga_sprite_timing_if.slave wr,
    output logic               o_pix_ce,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic               o_frame_start,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_green,
    output logic [COLOR_W-1:0] o_blue,
    output logic [N_SPR-1:0]   o_hit
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int H_OFF = H_SYNC + H_BP;
    localparam int V_OFF = V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW    = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int CW    = 3 * COLOR_W;

    logic [DW-1:0] div_reg;
    logic          started_reg;
    logic          pix_ce;
    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          h_last;
    logic          v_last;
    logic          commit;
    logic          wr_acc;
    logic          active;
    logic [XW:0]   px;
    logic [YW:0]   py;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic [N_SPR-1:0] hit;
    logic [CW-1:0] spr_color [N_SPR];
    logic [CW-1:0] pick;

    // Pixel divider; started_reg keeps the pixel enable low in reset even when CLK_DIV=1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_reg     <= '0;
            started_reg <= 1'b0;
        end else begin
            started_reg <= 1'b1;
            div_reg     <= (div_reg == DW'(CLK_DIV - 1)) ? '0 : div_reg + DW'(1);
        end
    end

    assign pix_ce   = started_reg && (div_reg == DW'(CLK_DIV - 1));
    assign o_pix_ce = pix_ce;

    assign h_last = (h_cnt_reg == HW'(H_TOT - 1));
    assign v_last = (v_cnt_reg == VW'(V_TOT - 1));

    // Raster counters; the line counter only moves when the pixel counter wraps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pix_ce) begin
            h_cnt_reg <= h_last ? '0 : h_cnt_reg + HW'(1);
            if (h_last) begin
                v_cnt_reg <= v_last ? '0 : v_cnt_reg + VW'(1);
            end
        end
    end

    // The frame's last pixel copies shadow to live; writes are held off for that one clock
    assign commit        = pix_ce && h_last && v_last;
    assign wr.o_wr_ready = ~commit;
    assign wr_acc        = wr.i_wr_valid && !commit;

`ifdef VGA_SPRITE_CLAMP_EN
    // Clamp so the whole sprite fits inside the active window
    always_comb begin
        x_in = (wr.i_x_pos > XW'(H_ACT - SPR_W)) ? XW'(H_ACT - SPR_W) : wr.i_x_pos;
        y_in = (wr.i_y_pos > YW'(V_ACT - SPR_H)) ? YW'(V_ACT - SPR_H) : wr.i_y_pos;
    end
`else
    // Positions pass through untouched; the active window clips overhang
    always_comb begin
        x_in = wr.i_x_pos;
        y_in = wr.i_y_pos;
    end
`endif

    assign active = (h_cnt_reg >= HW'(H_OFF)) && (h_cnt_reg < HW'(H_OFF + H_ACT)) &&
                    (v_cnt_reg >= VW'(V_OFF)) && (v_cnt_reg < VW'(V_OFF + V_ACT));

    // One extra bit so x+SPR_W past the right edge cannot wrap back on screen
    assign px = (XW+1)'(h_cnt_reg) - (XW+1)'(H_OFF);
    assign py = (YW+1)'(v_cnt_reg) - (YW+1)'(V_OFF);

    for (genvar gi = 0; gi < N_SPR; gi++) begin : g_spr
        logic [XW-1:0] x_sh_reg, x_lv_reg;
        logic [YW-1:0] y_sh_reg, y_lv_reg;
        logic [CW-1:0] c_sh_reg, c_lv_reg;
        logic          en_sh_reg, en_lv_reg;

        // Per-sprite shadow load on accepted writes, live copy at frame commit
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                x_sh_reg  <= '0;
                y_sh_reg  <= '0;
                c_sh_reg  <= '1;
                en_sh_reg <= 1'b0;
                x_lv_reg  <= '0;
                y_lv_reg  <= '0;
                c_lv_reg  <= '1;
                en_lv_reg <= 1'b0;
            end else begin
                if (wr_acc && (wr.i_wr_sel == SW'(gi))) begin
                    x_sh_reg  <= x_in;
                    y_sh_reg  <= y_in;
                    c_sh_reg  <= wr.i_color;
                    en_sh_reg <= wr.i_wr_en;
                end
                if (commit) begin
                    x_lv_reg  <= x_sh_reg;
                    y_lv_reg  <= y_sh_reg;
                    c_lv_reg  <= c_sh_reg;
                    en_lv_reg <= en_sh_reg;
                end
            end
        end

        assign hit[gi] = en_lv_reg && active &&
                         ({1'b0, x_lv_reg} <= px) && (px < {1'b0, x_lv_reg} + (XW+1)'(SPR_W)) &&
                         ({1'b0, y_lv_reg} <= py) && (py < {1'b0, y_lv_reg} + (YW+1)'(SPR_H));
        assign spr_color[gi] = c_lv_reg;
    end

    // Lowest-index hitting sprite wins; black when nothing hits
    always_comb begin
        pick = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pick = spr_color[i];
            end
        end
    end

    // All video outputs share one register stage so they stay aligned
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hs          <= 1'b0;
            o_vs          <= 1'b0;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_hit         <= '0;
        end else if (pix_ce) begin
            o_hs          <= (h_cnt_reg >= HW'(H_SYNC));
            o_vs          <= (v_cnt_reg >= VW'(V_SYNC));
            o_de          <= active;
            o_frame_start <= (h_cnt_reg == HW'(H_OFF)) && (v_cnt_reg == VW'(V_OFF));
            {o_red, o_green, o_blue} <= pick;
            o_hit         <= hit;
        end
    end
endmodule

// File: tb/tb_vga_sprite_timing.sv
// Randomized bench for vga_sprite_timing on a shrunken raster. The reference
// model derives every output from the absolute pixel index since reset.
module tb_vga_sprite_timing;
    localparam int HS = 4, HB = 3, HA = 20, HF = 3;
    localparam int VS = 2, VB = 2, VA = 12, VF = 2;
    localparam int D = 2, NS = 3, SPW = 5, SPH = 5, CWD = 4, XW = 6, YW = 6;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int SELW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic o_pix_ce, o_hs, o_vs, o_de, o_frame_start;
    logic [CWD-1:0] o_red, o_green, o_blue;
    logic [NS-1:0] o_hit;
    logic [31:0] dut_pix;

    vga_sprite_timing_if #(.N_SPR(NS), .XW(XW), .YW(YW), .COLOR_W(CWD)) wr ();

    vga_sprite_timing #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
        .CLK_DIV(D), .N_SPR(NS), .SPR_W(SPW), .SPR_H(SPH),
        .COLOR_W(CWD), .XW(XW), .YW(YW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .wr(wr),
        .o_pix_ce(o_pix_ce), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
        .o_frame_start(o_frame_start),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_hit(o_hit)
    );

    assign dut_pix = {12'b0, o_hs, o_vs, o_de, o_frame_start, o_red, o_green, o_blue, o_hit};

    int total = 0;
    int bad = 0;

    // model state
    int k;
    bit exp_ce;
    logic [31:0] exp_pix;
    int sx[NS], sy[NS], sc[NS];
    bit se[NS];
    int lx[NS], ly[NS], lc[NS];
    bit le[NS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        exp_ce = 1'b0;
        exp_pix = '0;
        for (int i = 0; i < NS; i++) begin
            sx[i] = 0; sy[i] = 0; sc[i] = 'hFFF; se[i] = 1'b0;
            lx[i] = 0; ly[i] = 0; lc[i] = 'hFFF; le[i] = 1'b0;
        end
    endtask

    // edge kk is a frame commit when it moves the raster into pixel 0 of a new frame
    function automatic bit commit_at(input int kk);
        return (kk > 0) && (kk % D == 0) && ((kk / D) % FT == 0);
    endfunction

    // expected packed outputs for absolute pixel pp
    function automatic logic [31:0] pix_at(input int pp);
        int h, v, px, py, col;
        bit hs, vs, act, fs, found;
        logic [NS-1:0] hv;
        logic [19:0] r;
        h = pp % HT;
        v = (pp / HT) % VT;
        hs = (h >= HS);
        vs = (v >= VS);
        act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        fs = (h == HS + HB) && (v == VS + VB);
        px = h - (HS + HB);
        py = v - (VS + VB);
        hv = '0;
        col = 0;
        found = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (act && le[i] && px >= lx[i] && px < lx[i] + SPW && py >= ly[i] && py < ly[i] + SPH) begin
                hv[i] = 1'b1;
                if (!found) begin
                    col = lc[i];
                    found = 1'b1;
                end
            end
        end
        r = {hs, vs, act, fs, col[11:0], hv};
        return {12'b0, r};
    endfunction

    // one clock: check previous edge's outputs, drive, advance model
    task automatic tick(input bit v, input int sel, input bit en, input int x, input int y, input int c);
        bit exp_rdy, acc;
        int xm, ym;
        chk("ce", 32'(o_pix_ce), 32'(exp_ce));
        chk("pix", dut_pix, exp_pix);
        wr.i_wr_valid = v;
        wr.i_wr_sel   = SELW'(sel);
        wr.i_wr_en    = en;
        wr.i_x_pos    = XW'(x);
        wr.i_y_pos    = YW'(y);
        wr.i_color    = 12'(c);
        exp_rdy = !commit_at(k + 1);
        #1;
        chk("rdy", 32'(wr.o_wr_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        k++;
        if (k % D == 0) exp_pix = pix_at(k / D - 1);
        exp_ce = (k % D == D - 1);
        if (commit_at(k)) begin
            for (int i = 0; i < NS; i++) begin
                lx[i] = sx[i]; ly[i] = sy[i]; lc[i] = sc[i]; le[i] = se[i];
            end
        end
        if (acc) begin
            xm = x; ym = y;
`ifdef VGA_SPRITE_CLAMP_EN
            if (xm > HA - SPW) xm = HA - SPW;
            if (ym > VA - SPH) ym = VA - SPH;
`endif
            if (sel < NS) begin
                sx[sel] = xm; sy[sel] = ym; sc[sel] = c; se[sel] = en;
            end
            $display("wr edge=%0d sel=%0d en=%0d x=%0d y=%0d color=%h%s", k, sel, en, xm, ym, c,
                     (sel < NS) ? "" : " (discarded)");
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ce"}, 32'(o_pix_ce), 32'd0);
        chk({tag, "_pix"}, dut_pix, 32'd0);
        chk({tag, "_rdy"}, 32'(wr.o_wr_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_k;
        wr.i_wr_valid = 1'b0;
        wr.i_wr_sel = '0;
        wr.i_wr_en = 1'b0;
        wr.i_x_pos = '0;
        wr.i_y_pos = '0;
        wr.i_color = '0;
        model_reset();
        #2;
        chk_reset("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // white sprite 0: frame 0 black, visible in frame 1
        tick(1'b1, 0, 1'b1, 10, 2, 'hFFF);
        idle(2 * FT * D);

        // overlapping red over blue
        tick(1'b1, 0, 1'b1, 5, 5, 'hF00);
        tick(1'b1, 1, 1'b1, 7, 6, 'h00F);
        idle(2 * FT * D);

        // right-edge sprite plus a discarded out-of-range select
        tick(1'b1, 2, 1'b1, HA - 2, 0, 'h0F0);
        tick(1'b1, 3, 1'b1, 1, 1, 'h123);
        idle(2 * FT * D);

        // hold a request across the commit clock
        while (!commit_at(k + 1)) idle(1);
        tick(1'b1, 2, 1'b1, 1, 9, 'h888);
        tick(1'b1, 2, 1'b1, 1, 9, 'h888);
        idle(2 * FT * D);

        // random traffic
        repeat (3 * FT * D) begin
            if ($urandom_range(7) == 0)
                tick(1'b1, int'($urandom_range(3)), 1'($urandom_range(1)), int'($urandom_range(63)),
                     int'($urandom_range(63)), int'($urandom_range(4095)));
            else
                idle(1);
        end

        // asynchronous reset in mid-line with a write pending
        tick(1'b1, 0, 1'b1, 3, 3, 'hABC);
        idle(D * HT + D * 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fs_k = -1;
        repeat (FT * D) begin
            if (o_frame_start === 1'b1 && fs_k < 0) fs_k = k;
            idle(1);
        end
        chk("fs_latency", 32'(fs_k), 32'(((VS + VB) * HT + HS + HB + 1) * D));
        idle(FT * D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
